// File: rtl/bitonic_batch_ctrl_if.sv
// Handshake and sorter bus for the bitonic batch controller.
// master = controller side, slave = upstream/sorter/downstream environment.
interface bitonic_batch_ctrl_if #(
  parameter int NUM_ELEMENTS = 16,
  parameter int DATA_W       = 32
);
  logic                           in_valid;
  logic                           in_ready;
  logic [DATA_W-1:0]              in_data;
  logic                           in_last;
  logic                           sort_launch;
  logic [NUM_ELEMENTS*DATA_W-1:0] sort_vec;
  logic [NUM_ELEMENTS*DATA_W-1:0] sort_res;
  logic                           out_valid;
  logic                           out_ready;
  logic [DATA_W-1:0]              out_data;
  logic                           out_last;

  modport master (
    input  in_valid, in_data, in_last, sort_res, out_ready,
    output in_ready, sort_launch, sort_vec, out_valid, out_data, out_last
  );

  modport slave (
    output in_valid, in_data, in_last, sort_res, out_ready,
    input  in_ready, sort_launch, sort_vec, out_valid, out_data, out_last
  );
endinterface

// File: rtl/bitonic_batch_ctrl.sv
// Collects a batch of elements, launches it into an external fixed-latency sorter,
// captures the sorted result and streams back only the real (non-pad) elements.
module bitonic_batch_ctrl #(
  parameter int                NUM_ELEMENTS = 16,
  parameter int                DATA_W       = 32,
  parameter int                SORT_LATENCY = 3,
  parameter logic [DATA_W-1:0] PAD_VALUE    = '1
) (
  input  logic                clk,
  input  logic                rst_n,
  bitonic_batch_ctrl_if.master bus,
  output logic                busy,
  output logic [15:0]         batch_cnt
);
  localparam int AW = $clog2(NUM_ELEMENTS);
  localparam int CW = AW + 1;
  localparam int LW = $clog2(SORT_LATENCY + 2);

  typedef enum logic [1:0] {S_FILL, S_LAUNCH, S_WAIT, S_DRAIN} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [LW-1:0]     lat_q, lat_d;
  logic [15:0]       batch_cnt_q, batch_cnt_d;
  logic [DATA_W-1:0] buf_q [NUM_ELEMENTS];
  logic              wr_en, cap_en, last_beat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_FILL;
      cnt_q       <= '0;
      idx_q       <= '0;
      lat_q       <= '0;
      batch_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      lat_q       <= lat_d;
      batch_cnt_q <= batch_cnt_d;
    end
  end

  // Data storage carries no reset; contents are masked by cnt until rewritten.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      buf_q[cnt_q[AW-1:0]] <= bus.in_data;
    end else if (cap_en) begin
      for (int i = 0; i < NUM_ELEMENTS; i++) begin
        buf_q[i] <= bus.sort_res[i*DATA_W +: DATA_W];
      end
    end
  end

  assign last_beat = ({1'b0, idx_q} == (cnt_q - 1'b1));

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    idx_d           = idx_q;
    lat_d           = lat_q;
    batch_cnt_d     = batch_cnt_q;
    wr_en           = 1'b0;
    cap_en          = 1'b0;
    bus.in_ready    = 1'b0;
    bus.sort_launch = 1'b0;
    bus.out_valid   = 1'b0;
    bus.out_last    = 1'b0;
    case (state_q)
      S_FILL: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          wr_en = 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (bus.in_last || (cnt_d == CW'(NUM_ELEMENTS))) begin
            state_d = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: begin
        bus.sort_launch = 1'b1;
        // A zero-latency sorter answers in the launch cycle itself.
        if (SORT_LATENCY == 0) begin
          cap_en  = 1'b1;
          state_d = S_DRAIN;
        end else begin
          lat_d   = LW'(SORT_LATENCY);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        lat_d = lat_q - 1'b1;
        if (lat_q == LW'(1)) begin
          cap_en  = 1'b1;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        bus.out_valid = 1'b1;
        bus.out_last  = last_beat;
        if (bus.out_ready) begin
          idx_d = idx_q + 1'b1;
          if (last_beat) begin
            batch_cnt_d = batch_cnt_q + 1'b1;
            cnt_d       = '0;
            idx_d       = '0;
            state_d     = S_FILL;
          end
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  // Slots beyond the fill count are presented as PAD_VALUE so they sort last.
  logic [NUM_ELEMENTS*DATA_W-1:0] sort_vec_w;
  for (genvar gi = 0; gi < NUM_ELEMENTS; gi++) begin : g_slot
    assign sort_vec_w[gi*DATA_W +: DATA_W] = (CW'(gi) < cnt_q) ? buf_q[gi] : PAD_VALUE;
  end

  assign bus.sort_vec = sort_vec_w;
  assign bus.out_data = buf_q[idx_q];
  assign busy         = !((state_q == S_FILL) && (cnt_q == '0));
  assign batch_cnt    = batch_cnt_q;
endmodule

// File: tb/tb_bitonic_batch_ctrl.sv
// Directed self-checking bench for bitonic_batch_ctrl with a 3-stage behavioural sorter.
module tb_bitonic_batch_ctrl;
  localparam int N = 16;
  localparam int W = 32;
  localparam logic [W-1:0] PAD = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        busy;
  logic [15:0] batch_cnt;
  int          checks = 0;
  int          errors = 0;

  logic [W-1:0]   in_arr  [N];
  logic [W-1:0]   exp_arr [N];
  logic [N*W-1:0] pipe    [3];

  bitonic_batch_ctrl_if #(.NUM_ELEMENTS(N), .DATA_W(W)) bus ();

  bitonic_batch_ctrl #(
    .NUM_ELEMENTS(N), .DATA_W(W), .SORT_LATENCY(3), .PAD_VALUE(PAD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .batch_cnt(batch_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [N*W-1:0] sort_f(input logic [N*W-1:0] v);
    logic [W-1:0]   a [N];
    logic [W-1:0]   t;
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) a[i] = v[i*W +: W];
    for (int i = 0; i < N - 1; i++)
      for (int j = 0; j < N - 1 - i; j++)
        if (a[j] > a[j+1]) begin
          t = a[j]; a[j] = a[j+1]; a[j+1] = t;
        end
    for (int i = 0; i < N; i++) r[i*W +: W] = a[i];
    return r;
  endfunction

  // Behavioural sorter: result appears exactly three edges after the launch cycle.
  always @(posedge clk) begin
    pipe[0] <= bus.sort_launch ? sort_f(bus.sort_vec) : {N{32'hBAD0BAD0}};
    pipe[1] <= pipe[0];
    pipe[2] <= pipe[1];
  end
  assign bus.sort_res = pipe[2];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int n, input bit with_last);
    for (int k = 0; k < n; k++) begin
      check("in_ready_fill", bus.in_ready, 1);
      check("busy_fill", busy, (k != 0));
      bus.in_valid = 1'b1;
      bus.in_data  = in_arr[k];
      bus.in_last  = with_last && (k == n - 1);
      @(posedge clk);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = 32'h0BAD_F00D;
  endtask

  task automatic check_vec(input int n);
    for (int j = 0; j < N; j++)
      check("sort_vec_slot", bus.sort_vec[j*W +: W], (j < n) ? in_arr[j] : PAD);
  endtask

  // Called at the negedge of the expected launch cycle; ends at the first DRAIN negedge.
  task automatic expect_launch(input int n);
    check("sort_launch", bus.sort_launch, 1);
    check("in_ready_launch", bus.in_ready, 0);
    check("busy_launch", busy, 1);
    check_vec(n);
    for (int j = 1; j <= 3; j++) begin
      @(negedge clk);
      check("launch_pulse", bus.sort_launch, 0);
      check("out_valid_wait", bus.out_valid, 0);
      check("in_ready_wait", bus.in_ready, 0);
      check_vec(n);
    end
    @(negedge clk);
    check("out_valid_latency", bus.out_valid, 1);
  endtask

  task automatic drain(input int n, input bit bp, input logic [15:0] exp_bc);
    int k = 0;
    int guard = 0;
    while (k < n && guard < 400) begin
      check("in_ready_drain", bus.in_ready, 0);
      check("out_valid", bus.out_valid, 1);
      check("out_data", bus.out_data, exp_arr[k]);
      check("out_last", bus.out_last, (k == n - 1));
      bus.out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk);
      if (bus.out_ready) k++;
      guard++;
      @(negedge clk);
    end
    check("drain_complete", k, n);
    bus.out_ready = 1'b1;
    check("in_ready_after", bus.in_ready, 1);
    check("out_valid_after", bus.out_valid, 0);
    check("busy_after", busy, 0);
    check("batch_cnt", batch_cnt, exp_bc);
  endtask

  task automatic check_reset_outputs();
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_sort_launch", bus.sort_launch, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_batch_cnt", batch_cnt, 0);
    check("rst_sort_vec_lo", bus.sort_vec[255:0], {8{PAD}});
    check("rst_sort_vec_hi", bus.sort_vec[511:256], {8{PAD}});
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs();

    // Full batch 15..0, launch on the 16th accept without in_last.
    for (int i = 0; i < N; i++) begin
      in_arr[i]  = 32'(15 - i);
      exp_arr[i] = 32'(i);
    end
    send(16, 1'b0);
    expect_launch(16);
    drain(16, 1'b0, 16'd1);

    // Partial flush 5,1,4 closed by in_last.
    in_arr[0] = 32'd5; in_arr[1] = 32'd1; in_arr[2] = 32'd4;
    exp_arr[0] = 32'd1; exp_arr[1] = 32'd4; exp_arr[2] = 32'd5;
    send(3, 1'b1);
    expect_launch(3);
    drain(3, 1'b0, 16'd2);

    // Backpressure with duplicates and zero.
    in_arr[0] = 32'd40; in_arr[1] = 32'd7;  in_arr[2] = 32'd33; in_arr[3] = 32'd7;
    in_arr[4] = 32'd0;  in_arr[5] = 32'd100; in_arr[6] = 32'd12; in_arr[7] = 32'd5;
    exp_arr[0] = 32'd0;  exp_arr[1] = 32'd5;  exp_arr[2] = 32'd7;  exp_arr[3] = 32'd7;
    exp_arr[4] = 32'd12; exp_arr[5] = 32'd33; exp_arr[6] = 32'd40; exp_arr[7] = 32'd100;
    send(8, 1'b1);
    expect_launch(8);
    drain(8, 1'b1, 16'd3);

    // Reset during WAIT discards the batch.
    in_arr[0] = 32'd9; in_arr[1] = 32'd8; in_arr[2] = 32'd3;
    send(3, 1'b1);
    check("sort_launch_rst", bus.sort_launch, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      check("out_valid_post_rst", bus.out_valid, 0);
      check("in_ready_post_rst", bus.in_ready, 1);
    end
    in_arr[0] = 32'd7; in_arr[1] = 32'd2; in_arr[2] = 32'd9;
    exp_arr[0] = 32'd2; exp_arr[1] = 32'd7; exp_arr[2] = 32'd9;
    send(3, 1'b1);
    expect_launch(3);
    drain(3, 1'b0, 16'd1);

    // in_last without in_valid must not close an empty batch.
    bus.in_last = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_last = 1'b0;
    check("lone_last_in_ready", bus.in_ready, 1);
    check("lone_last_launch", bus.sort_launch, 0);
    check("lone_last_busy", busy, 0);

    // Counter wrap from 16'hFFFF on a single-element batch.
    force dut.batch_cnt_q = 16'hFFFF;
    #1;
    release dut.batch_cnt_q;
    @(negedge clk);
    check("batch_cnt_preload", batch_cnt, 16'hFFFF);
    in_arr[0]  = 32'd42;
    exp_arr[0] = 32'd42;
    send(1, 1'b1);
    expect_launch(1);
    drain(1, 1'b0, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bitonic_batch_ctrl.md
BITONIC_BATCH_CTRL -- requirements
Module: bitonic_batch_ctrl

Interface
REQ-001 SHALL have parameter NUM_ELEMENTS, default 16, the sorter width (elements per batch, power of two).
REQ-002 SHALL have parameter DATA_W, default 32, the element width (matches pair.info).
REQ-003 SHALL have parameter SORT_LATENCY, default 3, the sorter pipeline depth in cycles (PIPELINES for the default sorter).
REQ-004 SHALL have parameter PAD_VALUE, default all-ones of DATA_W, the filler for unused slots (sorts last in ascending order).
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 in_valid  input  1  upstream element valid.
REQ-008 in_ready  output  1  controller accepts an element.
REQ-009 in_data  input  DATA_W  upstream element.
REQ-010 in_last  input  1  with in_valid: this element closes the batch (partial flush).
REQ-011 sort_launch  output  1  one-cycle pulse; sort_vec valid to sorter.
REQ-012 sort_vec  output  NUM_ELEMENTS*DATA_W  batch to sorter; slot i at bits [i*DATA_W +: DATA_W].
REQ-013 sort_res  input  NUM_ELEMENTS*DATA_W  sorter result, same slot layout.
REQ-014 out_valid  output  1  sorted element valid.
REQ-015 out_ready  input  1  downstream accepts.
REQ-016 out_data  output  DATA_W  sorted element.
REQ-017 out_last  output  1  final real element of the batch.
REQ-018 busy  output  1  high in every state except FILL with zero elements held.
REQ-019 batch_cnt  output  16  completed batches, wraps at 16'hFFFF -> 0.

Function
REQ-020 SHALL implement states FILL, LAUNCH, WAIT, DRAIN; one batch in flight at a time.
REQ-021 FILL: in_ready=1; each in_valid&&in_ready writes in_data to buf[cnt], cnt+=1 (cnt width $clog2(NUM_ELEMENTS)+1).
REQ-022 FILL -> LAUNCH on the accept making cnt==NUM_ELEMENTS, or on any accept with in_last=1.
REQ-023 in_ready SHALL be 0 in LAUNCH, WAIT, DRAIN; in_data ignored there.
REQ-024 LAUNCH (exactly one cycle): sort_launch=1; sort_vec slot i = buf[i] for i<cnt, PAD_VALUE for i>=cnt; next WAIT.
REQ-025 sort_vec SHALL be held stable from LAUNCH through the end of WAIT.
REQ-026 WAIT: latency counter loaded with SORT_LATENCY at launch; sort_res captured into buf on the edge exactly SORT_LATENCY cycles after the sort_launch cycle; next DRAIN.
REQ-027 SORT_LATENCY=0 SHALL capture sort_res on the LAUNCH edge itself (combinational sorter).
REQ-028 DRAIN: out_valid=1, out_data=buf[idx], out_last=(idx==cnt-1); idx+=1 on out_valid&&out_ready.
REQ-029 out_data/out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-030 Only cnt real elements emitted; pad slots never output.
REQ-031 On the handshake with out_last=1: batch_cnt+=1, cnt=0, idx=0, next FILL; in_ready=1 the following cycle.
REQ-032 in_last asserted without in_valid SHALL be ignored; a batch always holds >=1 element.
REQ-033 No registered input-to-output combinational path except none; in_ready and out_valid are decoded from registered state only.

Reset
REQ-034 While rst_n=0: state=FILL, cnt=0, idx=0, latency counter=0, batch_cnt=0, buf contents don't-care.
REQ-035 Reset outputs: in_ready=1, sort_launch=0, out_valid=0, out_last=0, busy=0, sort_vec=all PAD_VALUE.
REQ-036 Reset asserted mid-batch (any state) SHALL discard the batch; no partial output after release.

Verification
REQ-037 Full batch: 16 elements 15..0 back-to-back, out_ready=1 -> sort_launch one cycle after 16th accept, out 0..15 ascending, out_last on 15, batch_cnt=1.
REQ-038 Partial flush: 5,1,4 with in_last on 4 -> sort_vec slots 3..15 = 32'hFFFFFFFF; output 1,4,5, out_last on 5; no pad emitted.
REQ-039 Latency: launch at cycle T with SORT_LATENCY=3 -> capture edge T+3, first out_valid at T+4.
REQ-040 Backpressure: out_ready toggled 0/1 randomly -> out_data stable while stalled, no loss or duplication, in_ready=0 until out_last handshake.
REQ-041 Reset mid-WAIT: rst_n low 2 cycles -> all outputs at reset values immediately, batch_cnt=0, next batch sorted correctly.
REQ-042 Wrap: preload via 65536 single-element batches (or force) -> batch_cnt goes 16'hFFFF -> 0.
